// File: rtl/mem_arb_pkg.sv
// Shared core definitions for the memory arbiter: bus widths, FSM state
// encoding and transaction-owner encoding.
package mem_arb_pkg;

  // Byte-strobe width of the 32-bit data path.
  localparam int WSTRB_W = 4;

  // Arbiter FSM: wait for a request, present it to memory, wait for the reply.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // Which requester owns the in-flight transaction. The encoding doubles as
  // the grant-vector bit index (bit 0 = IFU, bit 1 = LSU).
  typedef enum logic {
    OWNER_IFU = 1'b0,
    OWNER_LSU = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arb_rr_arb2.sv
// Two-way round-robin grant. Bit 0 is the IFU and bit 1 is the LSU.
// 'last' names the requester granted most recently (0 = IFU, 1 = LSU).
module mem_arb_rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  // A lone requester always wins; on a tie the requester not granted last wins.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arb.sv
// Arbitrates the instruction-fetch and load/store ports onto one shared
// memory port, with at most one transaction in flight at a time.
module mem_arb
  import mem_arb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic               clk,
  input  logic               rst,
  // instruction fetch port
  input  logic               ifu_req_valid,
  output logic               ifu_req_ready,
  input  logic [XLEN-1:0]    ifu_req_addr,
  output logic               ifu_rsp_valid,
  output logic [XLEN-1:0]    ifu_rsp_rdata,
  // load/store port
  input  logic               lsu_req_valid,
  output logic               lsu_req_ready,
  input  logic [XLEN-1:0]    lsu_req_addr,
  input  logic               lsu_req_wen,
  input  logic [WSTRB_W-1:0] lsu_req_wstrb,
  input  logic [XLEN-1:0]    lsu_req_wdata,
  output logic               lsu_rsp_valid,
  output logic [XLEN-1:0]    lsu_rsp_rdata,
  // shared memory port
  output logic               mem_req_valid,
  input  logic               mem_req_ready,
  output logic [XLEN-1:0]    mem_req_addr,
  output logic               mem_req_wen,
  output logic [WSTRB_W-1:0] mem_req_wstrb,
  output logic [XLEN-1:0]    mem_req_wdata,
  input  logic               mem_rsp_valid,
  input  logic [XLEN-1:0]    mem_rsp_rdata
);

  arb_state_t         r_state;
  owner_t             r_owner;
  owner_t             r_last_grant;
  logic               r_mem_req_valid;
  logic [XLEN-1:0]    r_addr;
  logic               r_wen;
  logic [WSTRB_W-1:0] r_wstrb;
  logic [XLEN-1:0]    r_wdata;

  logic [1:0]         w_req;
  logic [1:0]         w_grant;
  logic               w_rsp_fire;

  // Requests are only offered to the arbiter while idle, so req_ready can
  // never rise while a transaction is still in flight.
  assign w_req = (r_state == IDLE) ? {lsu_req_valid, ifu_req_valid} : 2'b00;

  mem_arb_rr_arb2 u_rr (
    .req   (w_req),
    .last  (r_last_grant == OWNER_LSU),
    .grant (w_grant)
  );

  assign ifu_req_ready = w_grant[0];
  assign lsu_req_ready = w_grant[1];

  // Responses only count while waiting for one; anything else is dropped.
  assign w_rsp_fire    = (r_state == RESP) && mem_rsp_valid;
  assign ifu_rsp_valid = w_rsp_fire && (r_owner == OWNER_IFU);
  assign lsu_rsp_valid = w_rsp_fire && (r_owner == OWNER_LSU);
  assign ifu_rsp_rdata = mem_rsp_rdata;
  assign lsu_rsp_rdata = mem_rsp_rdata;

  assign mem_req_valid = r_mem_req_valid;
  assign mem_req_addr  = r_addr;
  assign mem_req_wen   = r_wen;
  assign mem_req_wstrb = r_wstrb;
  assign mem_req_wdata = r_wdata;

  // Arbiter FSM: latch the winner, hold the request until accepted, await reply.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= IDLE;
      r_owner         <= OWNER_IFU;
      r_last_grant    <= OWNER_IFU;
      r_mem_req_valid <= 1'b0;
      r_addr          <= '0;
      r_wen           <= 1'b0;
      r_wstrb         <= '0;
      r_wdata         <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_grant[1]) begin
            r_owner         <= OWNER_LSU;
            r_last_grant    <= OWNER_LSU;
            r_addr          <= lsu_req_addr;
            r_wen           <= lsu_req_wen;
            r_wstrb         <= lsu_req_wstrb;
            r_wdata         <= lsu_req_wdata;
            r_mem_req_valid <= 1'b1;
            r_state         <= REQ;
          end else if (w_grant[0]) begin
            // Fetches are always plain reads.
            r_owner         <= OWNER_IFU;
            r_last_grant    <= OWNER_IFU;
            r_addr          <= ifu_req_addr;
            r_wen           <= 1'b0;
            r_wstrb         <= '0;
            r_wdata         <= '0;
            r_mem_req_valid <= 1'b1;
            r_state         <= REQ;
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            r_state         <= RESP;
          end
        end
        RESP: begin
          if (mem_rsp_valid) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_mem_req_valid <= 1'b0;
          r_state         <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arb.sv
// Scoreboard bench for mem_arb: a behavioural memory, round-robin grant
// model and expected-transaction queues checked on every falling edge.
module tb_mem_arb;
  import mem_arb_pkg::*;

  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            ifu_req_valid, ifu_req_ready, ifu_rsp_valid;
  logic [XLEN-1:0] ifu_req_addr, ifu_rsp_rdata;
  logic            lsu_req_valid, lsu_req_ready, lsu_req_wen, lsu_rsp_valid;
  logic [XLEN-1:0] lsu_req_addr, lsu_req_wdata, lsu_rsp_rdata;
  logic [3:0]      lsu_req_wstrb;
  logic            mem_req_valid, mem_req_ready, mem_req_wen, mem_rsp_valid;
  logic [XLEN-1:0] mem_req_addr, mem_req_wdata, mem_rsp_rdata;
  logic [3:0]      mem_req_wstrb;

  mem_arb #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_addr(ifu_req_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_rdata(ifu_rsp_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
    .lsu_req_wen(lsu_req_wen), .lsu_req_wstrb(lsu_req_wstrb), .lsu_req_wdata(lsu_req_wdata),
    .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_rdata(lsu_rsp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_addr(mem_req_addr),
    .mem_req_wen(mem_req_wen), .mem_req_wstrb(mem_req_wstrb), .mem_req_wdata(mem_req_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        owner;
    logic [31:0] addr;
    logic        wen;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } req_t;

  typedef struct packed {
    logic        owner;
    logic        rd;
    logic [31:0] data;
    logic [31:0] acc_cyc;
  } rsp_t;

  req_t req_q[$];
  rsp_t rsp_q[$];
  logic grant_log[$];

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   ready_delay = 0;
  logic mem_auto = 1'b1;
  logic busy   = 1'b0;
  logic m_last = 1'b0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Behavioural memory contents.
  function automatic logic [31:0] mem_data(input logic [31:0] addr);
    if (addr == 32'h100) return 32'hDEADBEEF;
    return {addr[15:0] ^ 16'h5A5A, addr[15:0]};
  endfunction

  // Reference round-robin: lone requester wins, tie goes to the one not granted last.
  function automatic logic [1:0] exp_grant(input logic iv, input logic lv, input logic last_lsu);
    if (iv && lv) return last_lsu ? 2'b01 : 2'b10;
    return {lv, iv};
  endfunction

  // Memory responder: ready after ready_delay wait cycles, reply the cycle after handshake.
  initial begin : mem_model
    logic        hs, rst_s;
    logic [31:0] hs_addr;
    int          wcnt;
    wcnt = 0;
    forever begin
      @(negedge clk);
      hs      = mem_req_valid && mem_req_ready && !rst;
      rst_s   = rst;
      hs_addr = mem_req_addr;
      @(posedge clk); #1;
      if (mem_auto) begin
        mem_rsp_valid = 1'b0;
        if (rst_s) begin
          mem_req_ready = 1'b0;
          wcnt = 0;
        end else if (hs) begin
          mem_req_ready = 1'b0;
          mem_rsp_valid = 1'b1;
          mem_rsp_rdata = mem_data(hs_addr);
          wcnt = 0;
        end else if (mem_req_valid) begin
          mem_req_ready = (wcnt >= ready_delay);
          wcnt++;
        end else begin
          mem_req_ready = 1'b0;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Monitor: checks grants, memory requests and responses against the scoreboard.
  initial begin : monitor
    req_t       er;
    rsp_t       ep;
    logic [1:0] g;
    logic       prev_v, prev_hs;
    int         vrun;
    prev_v = 1'b0; prev_hs = 1'b0; vrun = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        busy = 1'b0; m_last = 1'b0;
        req_q.delete(); rsp_q.delete(); grant_log.delete();
        prev_v = 1'b0; prev_hs = 1'b0; vrun = 0;
      end else begin
        g = busy ? 2'b00 : exp_grant(ifu_req_valid, lsu_req_valid, m_last);
        check("ifu_req_ready", ifu_req_ready, g[0]);
        check("lsu_req_ready", lsu_req_ready, g[1]);

        if (ifu_rsp_valid || lsu_rsp_valid) begin
          check("rsp_both", ifu_rsp_valid && lsu_rsp_valid, 0);
          if (rsp_q.size() == 0) begin
            check("rsp_unexpected", {ifu_rsp_valid, lsu_rsp_valid}, 0);
          end else begin
            ep = rsp_q.pop_front();
            check("rsp_owner", lsu_rsp_valid, ep.owner);
            if (ep.rd) check("rsp_rdata", ep.owner ? lsu_rsp_rdata : ifu_rsp_rdata, ep.data);
            if (mem_auto) check("rsp_latency", cyc - int'(ep.acc_cyc), 2 + ready_delay);
            $display("[TB] rsp %s %s data=%08h cyc=%0d", ep.owner ? "LSU" : "IFU",
                     ep.rd ? "read " : "write", ep.owner ? lsu_rsp_rdata : ifu_rsp_rdata, cyc);
            busy = 1'b0;
          end
        end

        if (lsu_req_valid && lsu_req_ready) begin
          req_q.push_back('{1'b1, lsu_req_addr, lsu_req_wen, lsu_req_wstrb, lsu_req_wdata});
          rsp_q.push_back('{1'b1, !lsu_req_wen, mem_data(lsu_req_addr), cyc});
          grant_log.push_back(1'b1);
          busy = 1'b1; m_last = 1'b1;
        end else if (ifu_req_valid && ifu_req_ready) begin
          req_q.push_back('{1'b0, ifu_req_addr, 1'b0, 4'b0000, 32'h0});
          rsp_q.push_back('{1'b0, 1'b1, mem_data(ifu_req_addr), cyc});
          grant_log.push_back(1'b0);
          busy = 1'b1; m_last = 1'b0;
        end

        if (prev_v && !prev_hs) check("mem_req_hold", mem_req_valid, 1);
        if (mem_req_valid) begin
          vrun++;
          if (req_q.size() == 0) begin
            check("mem_req_unexpected", mem_req_valid, 0);
          end else begin
            er = req_q[0];
            check("mem_req_addr", mem_req_addr, er.addr);
            check("mem_req_wen", mem_req_wen, er.wen);
            check("mem_req_wstrb", mem_req_wstrb, er.wstrb);
            check("mem_req_wdata", mem_req_wdata, er.wdata);
            if (mem_req_ready) begin
              void'(req_q.pop_front());
              if (mem_auto) check("mem_req_valid_cycles", vrun, ready_delay + 1);
              vrun = 0;
            end
          end
        end else begin
          vrun = 0;
        end
        prev_v  = mem_req_valid;
        prev_hs = mem_req_valid && mem_req_ready;
      end
    end
  end

  task automatic ifu_send(input logic [31:0] addr);
    int t = 0;
    ifu_req_valid = 1'b1; ifu_req_addr = addr;
    do begin @(negedge clk); t++; end while (!ifu_req_ready && t < 200);
    check("ifu_accept_timeout", (t < 200), 1);
    @(posedge clk); #1;
    ifu_req_valid = 1'b0; ifu_req_addr = '0;
  endtask

  task automatic lsu_send(input logic [31:0] addr, input logic wen,
                          input logic [3:0] wstrb, input logic [31:0] wdata);
    int t = 0;
    lsu_req_valid = 1'b1; lsu_req_addr = addr; lsu_req_wen = wen;
    lsu_req_wstrb = wstrb; lsu_req_wdata = wdata;
    do begin @(negedge clk); t++; end while (!lsu_req_ready && t < 200);
    check("lsu_accept_timeout", (t < 200), 1);
    @(posedge clk); #1;
    lsu_req_valid = 1'b0; lsu_req_addr = '0; lsu_req_wen = 1'b0;
    lsu_req_wstrb = '0; lsu_req_wdata = '0;
  endtask

  task automatic wait_done();
    int t = 0;
    while ((busy || rsp_q.size() != 0) && t < 100) begin @(posedge clk); t++; end
    check("drain_timeout", (t < 100), 1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic set_auto(input logic v);
    @(posedge clk); #2;
    mem_auto = v; mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
  endtask

  initial begin : main
    logic exp_order [4];
    rst = 1'b1;
    ifu_req_valid = 1'b0; ifu_req_addr = '0;
    lsu_req_valid = 1'b0; lsu_req_addr = '0; lsu_req_wen = 1'b0;
    lsu_req_wstrb = '0; lsu_req_wdata = '0;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_mem_req_addr", mem_req_addr, 0);
    check("rst_mem_req_wen", mem_req_wen, 0);
    check("rst_mem_req_wstrb", mem_req_wstrb, 0);
    check("rst_mem_req_wdata", mem_req_wdata, 0);
    check("rst_rsp_valid", {ifu_rsp_valid, lsu_rsp_valid}, 0);
    check("rst_req_ready", {ifu_req_ready, lsu_req_ready}, 0);
    @(posedge clk); #1; rst = 1'b0;

    // Single IFU read, LSU store, LSU load
    ifu_send(32'h100); wait_done();
    lsu_send(32'h204, 1'b1, 4'b1100, 32'h12340000); wait_done();
    lsu_send(32'h208, 1'b0, 4'b0000, 32'h0); wait_done();

    // Both valid continuously after reset: LSU, IFU, LSU, IFU
    do_reset();
    fork
      begin ifu_send(32'h800); ifu_send(32'h804); end
      begin lsu_send(32'h900, 1'b0, 4'b0, 32'h0); lsu_send(32'h904, 1'b1, 4'b1111, 32'hA5A5A5A5); end
    join
    wait_done();
    exp_order[0] = 1'b1; exp_order[1] = 1'b0; exp_order[2] = 1'b1; exp_order[3] = 1'b0;
    check("grant_count", grant_log.size(), 4);
    for (int i = 0; i < 4 && i < grant_log.size(); i++) check("grant_order", grant_log[i], exp_order[i]);

    // Memory back-pressure: ready held low for 5 cycles
    ready_delay = 5;
    lsu_send(32'h30C, 1'b1, 4'b0011, 32'hCAFEF00D); wait_done();
    ifu_send(32'h400); wait_done();
    ready_delay = 0;

    // Spurious memory response while idle
    set_auto(1'b0);
    @(posedge clk); #1; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h11111111;
    @(negedge clk);
    check("idle_spurious_ifu_rsp", ifu_rsp_valid, 0);
    check("idle_spurious_lsu_rsp", lsu_rsp_valid, 0);
    @(posedge clk); #1; mem_rsp_valid = 1'b0;

    // Reset while the request is pending in REQ
    set_auto(1'b1);
    ready_delay = 10;
    ifu_send(32'h500);
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    check("rst_in_req_valid", mem_req_valid, 0);
    ready_delay = 0;

    // Reset while waiting in RESP, then a late response
    set_auto(1'b0);
    ifu_send(32'h600);
    mem_req_ready = 1'b1;
    @(posedge clk); #1; mem_req_ready = 1'b0; rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0; mem_rsp_valid = 1'b1; mem_rsp_rdata = 32'h77777777;
    @(negedge clk);
    check("late_rsp_ifu", ifu_rsp_valid, 0);
    check("late_rsp_lsu", lsu_rsp_valid, 0);
    @(posedge clk); #1; mem_rsp_valid = 1'b0;

    // Recovery: normal traffic resumes from IDLE
    set_auto(1'b1);
    lsu_send(32'h700, 1'b0, 4'b0, 32'h0); wait_done();
    ifu_send(32'h104); wait_done();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arb.md
MEM_ARB -- requirements
Module: MEM_ARB

Interface
REQ-001 Parameter XLEN, default 32, data/address width.
REQ-002 clk  input  1  core clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 ifu_req_valid  input  1  instruction fetch read request.
REQ-005 ifu_req_ready  output  1  IFU request accepted this cycle.
REQ-006 ifu_req_addr  input  XLEN  IFU word address.
REQ-007 ifu_rsp_valid  output  1  one-cycle pulse; IFU read data valid.
REQ-008 ifu_rsp_rdata  output  XLEN  IFU read data.
REQ-009 lsu_req_valid  input  1  load/store request.
REQ-010 lsu_req_ready  output  1  LSU request accepted this cycle.
REQ-011 lsu_req_addr  input  XLEN  LSU address.
REQ-012 lsu_req_wen  input  1  1 = store, 0 = load.
REQ-013 lsu_req_wstrb  input  4  store byte strobe.
REQ-014 lsu_req_wdata  input  XLEN  store data.
REQ-015 lsu_rsp_valid  output  1  one-cycle pulse; load data valid or store complete.
REQ-016 lsu_rsp_rdata  output  XLEN  load data.
REQ-017 mem_req_valid / mem_req_ready  output / input  1  shared memory request handshake.
REQ-018 mem_req_addr, mem_req_wen, mem_req_wstrb, mem_req_wdata  output  XLEN/1/4/XLEN  registered request fields.
REQ-019 mem_rsp_valid  input  1  memory response for reads and writes.
REQ-020 mem_rsp_rdata  input  XLEN  memory read data.

Function
REQ-021 FSM states IDLE, REQ, RESP; one outstanding transaction at most.
REQ-022 IDLE: if any request valid, grant one winner, assert only its req_ready combinationally, latch its fields and owner, go to REQ next cycle.
REQ-023 Arbitration is round-robin: a single requester always wins; when both are valid, the one not granted last wins; last_grant updates on acceptance.
REQ-024 An IFU grant latches wen=0, wstrb=4'b0000, wdata=0.
REQ-025 REQ: mem_req_valid=1 with latched fields held stable until mem_req_ready=1; on handshake go to RESP.
REQ-026 RESP: on mem_rsp_valid=1, pulse the owner's rsp_valid in the same cycle (combinational), then go to IDLE.
REQ-027 ifu_rsp_rdata and lsu_rsp_rdata both equal mem_rsp_rdata; only rsp_valid is gated by owner.
REQ-028 mem_rsp_valid outside RESP is ignored; no rsp_valid is produced.
REQ-029 req_ready is 0 in REQ and RESP; new requests are never accepted before the current response is delivered.
REQ-030 Latency: accept in cycle N, mem_req_valid in N+1; with immediate ready and next-cycle response, rsp_valid in N+2 and next accept in N+3.
REQ-031 Requesters keep valid and fields stable until ready; a request dropped before ready is never issued.

Reset
REQ-032 When rst=1 at a clock edge: state=IDLE, last_grant=IFU (LSU wins the first tie), owner=IFU, latched fields=0.
REQ-033 Outputs after reset: mem_req_valid=0, all req_ready and rsp_valid driven per IDLE and input state, mem_req_* fields=0.
REQ-034 Reset during REQ or RESP abandons the transaction: mem_req_valid is 0 the following cycle, and a late mem_rsp_valid produces no rsp_valid.

Structure
REQ-035 State enum (IDLE/REQ/RESP) and owner enum (OWNER_IFU/OWNER_LSU) are defined in the shared core package/header alongside the ISA definitions.
REQ-036 Round-robin grant logic is a separate sub-module RR_ARB2 (req[1:0], last, grant[1:0]); everything else is in MEM_ARB.

Verification
REQ-037 IFU read addr 0x100, mem ready immediately, rsp next cycle with rdata 0xDEADBEEF -> ifu_rsp_valid pulse with 0xDEADBEEF; mem_req_wen=0, wstrb=0.
REQ-038 LSU store addr 0x204, wstrb 4'b1100, wdata 0x12340000 -> mem fields match exactly; lsu_rsp_valid pulses once; ifu_rsp_valid stays 0.
REQ-039 Both valid continuously after reset -> grants alternate LSU, IFU, LSU, IFU, with exactly one req_ready per acceptance.
REQ-040 mem_req_ready low for 5 cycles -> mem_req_valid and all fields stable for 6 cycles; both req_ready stay 0.
REQ-041 Spurious mem_rsp_valid in IDLE, and rst asserted in RESP followed by a late mem_rsp_valid -> no rsp_valid in either case; state returns to IDLE.
